// File: rtl/accelerator_matrix_feeder_pkg.sv
// rtl/accelerator_matrix_feeder_pkg.sv - FSM encoding and sizing helpers for the matrix feeder
package accelerator_matrix_feeder_pkg;

  localparam int DEFAULT_DEPTH = 256;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_WAIT    = 2'd3
  } state_t;

  function automatic int addr_size_f(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/accelerator_matrix_feeder_ram.sv
// rtl/accelerator_matrix_feeder_ram.sv - 1W1R synchronous read-first RAM holding the matrix
module accelerator_matrix_feeder_ram #(
  parameter int DATA_SIZE = 64,
  parameter int DEPTH     = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [DATA_SIZE-1:0] rd_data
);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [DATA_SIZE-1:0] rd_data_q;

  // Read samples the array before the same-edge write lands: read-first.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/accelerator_matrix_feeder.sv
// rtl/accelerator_matrix_feeder.sv - RAM-backed matrix stream source with I/K enable handshake
// Optional column-major readout via ACCELERATOR_MATRIX_FEEDER_TRANSPOSE_EN (adds TRANSPOSE port).
module accelerator_matrix_feeder
  import accelerator_matrix_feeder_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int DEPTH        = DEFAULT_DEPTH,
  localparam int ADDR_SIZE   = addr_size_f(DEPTH)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [CONTROL_SIZE-1:0] SIZE_I_IN,
  input  logic [CONTROL_SIZE-1:0] SIZE_K_IN,
`ifdef ACCELERATOR_MATRIX_FEEDER_TRANSPOSE_EN
  input  logic                    TRANSPOSE,
`endif
  input  logic                    LOAD_ENABLE,
  input  logic [ADDR_SIZE-1:0]    LOAD_ADDR,
  input  logic [DATA_SIZE-1:0]    LOAD_DATA,
  output logic [DATA_SIZE-1:0]    DATA_OUT,
  output logic                    DATA_IN_I_ENABLE,
  output logic                    DATA_IN_K_ENABLE,
  input  logic                    DATA_OUT_I_ENABLE,
  input  logic                    DATA_OUT_K_ENABLE
);

  state_t                  state_q, state_d;
  logic [CONTROL_SIZE-1:0] size_i_q, size_i_d;
  logic [CONTROL_SIZE-1:0] size_k_q, size_k_d;
  logic [CONTROL_SIZE-1:0] i_q, i_d;
  logic [CONTROL_SIZE-1:0] k_q, k_d;
  logic [CONTROL_SIZE-1:0] addr_q, addr_d;
  logic [DATA_SIZE-1:0]    data_out_q, data_out_d;
  logic                    ready_q, ready_d;
  logic                    transpose_q, transpose_d;

  logic [DATA_SIZE-1:0]    ram_rd_data;
  logic [DATA_SIZE-1:0]    present_data;
  logic [CONTROL_SIZE-1:0] next_addr;
  logic                    last_i, last_k, request, oob, start_transpose;

  accelerator_matrix_feeder_ram #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_ram (
    .clk     (CLK),
    .wr_en   (LOAD_ENABLE),
    .wr_addr (LOAD_ADDR),
    .wr_data (LOAD_DATA),
    .rd_en   (state_q == ST_FETCH),
    .rd_addr (addr_q[ADDR_SIZE-1:0]),
    .rd_data (ram_rd_data)
  );

`ifdef ACCELERATOR_MATRIX_FEEDER_TRANSPOSE_EN
  assign start_transpose = TRANSPOSE;
`else
  assign start_transpose = 1'b0;
`endif

  // Addresses past the RAM saturate to zero data instead of wrapping.
  assign oob          = (addr_q >= CONTROL_SIZE'(DEPTH));
  assign present_data = oob ? '0 : ram_rd_data;
  assign last_i       = (i_q == size_i_q - CONTROL_SIZE'(1));
  assign last_k       = (k_q == size_k_q - CONTROL_SIZE'(1));
  assign request      = DATA_OUT_I_ENABLE | DATA_OUT_K_ENABLE;

  // Column-major walks a column stride and restarts at the next row index on wrap.
  always_comb begin
    next_addr = addr_q + CONTROL_SIZE'(1);
    if (transpose_q) begin
      next_addr = last_k ? (i_q + CONTROL_SIZE'(1)) : (addr_q + size_i_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    size_i_d    = size_i_q;
    size_k_d    = size_k_q;
    i_d         = i_q;
    k_d         = k_q;
    addr_d      = addr_q;
    data_out_d  = data_out_q;
    transpose_d = transpose_q;
    ready_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          size_i_d    = SIZE_I_IN;
          size_k_d    = SIZE_K_IN;
          transpose_d = start_transpose;
          i_d         = '0;
          k_d         = '0;
          addr_d      = '0;
          if ((SIZE_I_IN == '0) || (SIZE_K_IN == '0)) begin
            ready_d = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: state_d = ST_PRESENT;
      ST_PRESENT: begin
        data_out_d = present_data;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (request) begin
          if (last_i && last_k) begin
            ready_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FETCH;
            addr_d  = next_addr;
            if (last_k) begin
              k_d = '0;
              i_d = i_q + CONTROL_SIZE'(1);
            end else begin
              k_d = k_q + CONTROL_SIZE'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      size_i_q    <= '0;
      size_k_q    <= '0;
      i_q         <= '0;
      k_q         <= '0;
      addr_q      <= '0;
      data_out_q  <= '0;
      ready_q     <= 1'b0;
      transpose_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_i_q    <= size_i_d;
      size_k_q    <= size_k_d;
      i_q         <= i_d;
      k_q         <= k_d;
      addr_q      <= addr_d;
      data_out_q  <= data_out_d;
      ready_q     <= ready_d;
      transpose_q <= transpose_d;
    end
  end

  assign DATA_OUT         = (state_q == ST_PRESENT) ? present_data : data_out_q;
  assign DATA_IN_K_ENABLE = (state_q == ST_PRESENT);
  assign DATA_IN_I_ENABLE = (state_q == ST_PRESENT) && (k_q == '0);
  assign READY            = ready_q;

endmodule

// File: tb/tb_accelerator_matrix_feeder.sv
// tb/tb_accelerator_matrix_feeder.sv - scoreboard bench for accelerator_matrix_feeder
module tb_accelerator_matrix_feeder;

  localparam int DW    = 16;
  localparam int CW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  typedef struct {
    logic [DW-1:0] data;
    logic          first;
  } exp_t;

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic          READY;
  logic [CW-1:0] SIZE_I_IN = '0;
  logic [CW-1:0] SIZE_K_IN = '0;
  logic          TRANSPOSE = 1'b0;
  logic          LOAD_ENABLE = 1'b0;
  logic [AW-1:0] LOAD_ADDR = '0;
  logic [DW-1:0] LOAD_DATA = '0;
  logic [DW-1:0] DATA_OUT;
  logic          DATA_IN_I_ENABLE, DATA_IN_K_ENABLE;
  logic          DATA_OUT_I_ENABLE = 1'b0;
  logic          DATA_OUT_K_ENABLE = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc, last_evt;
  bit first_pending = 0;
  int pending_ready = 0;
  int elem_cnt = 0;
  int hold_at = 32'h7fff_ffff;
  int epoch = 0;
  int max_delay = 0;
  exp_t exp_q[$];
  logic [DW-1:0] mem_m [DEPTH];

  accelerator_matrix_feeder #(
    .DATA_SIZE    (DW),
    .CONTROL_SIZE (CW),
    .DEPTH        (DEPTH)
  ) dut (
    .CLK               (clk),
    .RST               (RST),
    .START             (START),
    .READY             (READY),
    .SIZE_I_IN         (SIZE_I_IN),
    .SIZE_K_IN         (SIZE_K_IN),
`ifdef ACCELERATOR_MATRIX_FEEDER_TRANSPOSE_EN
    .TRANSPOSE         (TRANSPOSE),
`endif
    .LOAD_ENABLE       (LOAD_ENABLE),
    .LOAD_ADDR         (LOAD_ADDR),
    .LOAD_DATA         (LOAD_DATA),
    .DATA_OUT          (DATA_OUT),
    .DATA_IN_I_ENABLE  (DATA_IN_I_ENABLE),
    .DATA_IN_K_ENABLE  (DATA_IN_K_ENABLE),
    .DATA_OUT_I_ENABLE (DATA_OUT_I_ENABLE),
    .DATA_OUT_K_ENABLE (DATA_OUT_K_ENABLE)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every presented element and every READY is matched against the scoreboard.
  always @(negedge clk) begin
    if (RST) begin
      if (DATA_IN_I_ENABLE && !DATA_IN_K_ENABLE) check_val("i_without_k", 1, 0);
      if (DATA_IN_K_ENABLE) begin
        elem_cnt++;
        if (exp_q.size() == 0) begin
          check_val("unexpected_element", DATA_OUT, 0);
          errors += (DATA_OUT == 0) ? 1 : 0;
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_val("data_out", DATA_OUT, e.data);
          check_val("i_enable", DATA_IN_I_ENABLE, e.first);
          if (first_pending) begin
            first_pending = 0;
            check_val("first_latency", cyc - start_cyc, 2);
          end
        end
      end
      if (READY) begin
        check_val("ready_expected", (pending_ready > 0) ? 1 : 0, 1);
        if (pending_ready > 0) pending_ready--;
        check_val("ready_left_elems", exp_q.size(), 0);
        check_val("ready_timing", cyc, last_evt + 1);
      end
    end
  end

  // Consumer: answers each presented element after a random delay with I, K or both.
  initial begin : consumer
    forever begin
      @(negedge clk);
      if (RST && DATA_IN_K_ENABLE) begin
        int ep, d, sel;
        ep = epoch;
        d = $urandom_range(0, max_delay);
        @(negedge clk);
        repeat (d) @(negedge clk);
        while (elem_cnt >= hold_at) @(negedge clk);
        if (ep == epoch && RST) begin
          sel = $urandom_range(0, 2);
          DATA_OUT_I_ENABLE = (sel != 1);
          DATA_OUT_K_ENABLE = (sel != 0);
          last_evt = cyc;
          @(negedge clk);
          DATA_OUT_I_ENABLE = 1'b0;
          DATA_OUT_K_ENABLE = 1'b0;
        end
      end
    end
  end

  task automatic load(input int a, input logic [DW-1:0] v);
    @(negedge clk);
    LOAD_ENABLE = 1'b1;
    LOAD_ADDR   = AW'(a);
    LOAD_DATA   = v;
    mem_m[a]    = v;
    @(negedge clk);
    LOAD_ENABLE = 1'b0;
  endtask

  task automatic start_stream(input int si, input int sk, input bit tr, input int dly);
    exp_t e;
    max_delay = dly;
    for (int i = 0; i < si; i++) begin
      for (int k = 0; k < sk; k++) begin
        int a;
        a = tr ? (k * si + i) : (i * sk + k);
        e.data  = (a < DEPTH) ? mem_m[a] : '0;
        e.first = (k == 0);
        exp_q.push_back(e);
      end
    end
    pending_ready++;
    @(negedge clk);
    START     = 1'b1;
    SIZE_I_IN = CW'(si);
    SIZE_K_IN = CW'(sk);
    TRANSPOSE = tr;
    start_cyc = cyc;
    last_evt  = cyc;
    first_pending = (si * sk > 0);
    @(negedge clk);
    START     = 1'b0;
    SIZE_I_IN = CW'($urandom);
    SIZE_K_IN = CW'($urandom);
    TRANSPOSE = ~tr;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((pending_ready != 0) && (n < 3000)) begin
      @(negedge clk);
      n++;
    end
    check_val({name, "_done"}, pending_ready, 0);
    if (pending_ready != 0) begin
      pending_ready = 0;
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_stream(input string name, input int si, input int sk, input bit tr, input int dly);
    start_stream(si, sk, tr, dly);
    wait_done(name);
  endtask

  initial begin : main
    int base, n;
    #3 RST = 1'b0;
    #1;
    check_val("rst_data_out", DATA_OUT, 0);
    check_val("rst_ready", READY, 0);
    check_val("rst_k_en", DATA_IN_K_ENABLE, 0);
    check_val("rst_i_en", DATA_IN_I_ENABLE, 0);
    repeat (3) @(negedge clk);
    RST = 1'b1;

    for (int a = 0; a < 6; a++) load(a, DW'(10 + a));
    run_stream("basic", 2, 3, 0, 0);
    run_stream("backpressure", 2, 3, 0, 7);
    run_stream("zero_i", 0, 4, 0, 0);
    run_stream("zero_k", 3, 0, 0, 0);

    for (int a = 0; a < DEPTH; a++) load(a, DW'($urandom));
    start_stream(2, 6, 0, 3);
    repeat (4) @(negedge clk);
    START = 1'b1;
    SIZE_I_IN = 1;
    SIZE_K_IN = 1;
    @(negedge clk);
    START = 1'b0;
    wait_done("overflow_midstart");

    for (int a = 0; a < 6; a++) load(a, DW'(10 + a));
    base = elem_cnt;
    hold_at = base + 3;
    start_stream(2, 3, 0, 0);
    n = 0;
    while ((elem_cnt < base + 3) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    check_val("abort_reach_elem2", (elem_cnt >= base + 3) ? 1 : 0, 1);
    @(posedge clk);
    #1 RST = 1'b0;
    #1;
    check_val("abort_data_out", DATA_OUT, 0);
    check_val("abort_ready", READY, 0);
    check_val("abort_k_en", DATA_IN_K_ENABLE, 0);
    epoch++;
    exp_q.delete();
    pending_ready = 0;
    first_pending = 0;
    hold_at = 32'h7fff_ffff;
    repeat (3) @(negedge clk);
    RST = 1'b1;
    run_stream("after_abort", 2, 3, 0, 2);

`ifdef ACCELERATOR_MATRIX_FEEDER_TRANSPOSE_EN
    run_stream("transpose", 2, 3, 1, 1);
`endif

    for (int r = 0; r < 8; r++) begin
      bit tr;
      for (int a = 0; a < DEPTH; a++) load(a, DW'($urandom));
`ifdef ACCELERATOR_MATRIX_FEEDER_TRANSPOSE_EN
      tr = 1'($urandom_range(0, 1));
`else
      tr = 1'b0;
`endif
      run_stream("random", $urandom_range(0, 3), $urandom_range(0, 5), tr, $urandom_range(0, 7));
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
